// File: rtl/pwm_duty_decoder_if.sv
// Receive-side PWM decoder bus: the waveform in, decoded duty/status out.
interface pwm_duty_decoder_if #(
    parameter int unsigned WIN_BITS = 8
);
    logic                pwm_in;
    logic [WIN_BITS-1:0] duty;
    logic                duty_valid;
    logic                dead;
    logic                locked;

    // master drives the waveform and consumes the decoded result
    modport master (
        output pwm_in,
        input  duty,
        input  duty_valid,
        input  dead,
        input  locked
    );

    modport slave (
        input  pwm_in,
        output duty,
        output duty_valid,
        output dead,
        output locked
    );
endinterface

// File: rtl/pwm_duty_decoder.sv
// Recovers the duty code of a periodic PWM waveform by counting high samples
// over 2^WIN_BITS-clock windows; reports code, stuck-low and lock status.
module pwm_duty_decoder #(
    parameter int unsigned WIN_BITS = 8,
    parameter int unsigned LOCK_N   = 2
) (
    input  logic               clk,
    input  logic               rst,
    pwm_duty_decoder_if.slave  bus
);

    localparam int unsigned TW = WIN_BITS + 1;
    localparam int unsigned MW = 4;
    localparam logic [MW-1:0]       LOCK_M   = MW'(LOCK_N);
    localparam logic [WIN_BITS-1:0] WIN_LAST = '1;

    typedef enum logic [0:0] {
        PRIME = 1'b0,
        TRACK = 1'b1
    } state_t;

    logic                sync1;
    logic                s;
    logic [WIN_BITS-1:0] win_cnt;
    logic [TW-1:0]       hi_cnt;
    logic [TW-1:0]       total_q;
    logic                win_end_q;

    state_t              state;
    state_t              state_nxt;
    logic [MW-1:0]       match_cnt;
    logic [MW-1:0]       match_nxt;
    logic [TW-1:0]       prev_total;
    logic [TW-1:0]       prev_nxt;
    logic [WIN_BITS-1:0] duty_q;
    logic [WIN_BITS-1:0] duty_nxt;
    logic                dv_q;
    logic                dv_nxt;
    logic                dead_q;
    logic                dead_nxt;
    logic                lock_q;
    logic                lock_nxt;

    // Synchroniser and window accumulator; hi_cnt restarts on the window's
    // first sample so the last sample is folded into total without loss.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= 1'b0;
            s         <= 1'b0;
            win_cnt   <= '0;
            hi_cnt    <= '0;
            total_q   <= '0;
            win_end_q <= 1'b0;
        end else begin
            sync1     <= bus.pwm_in;
            s         <= sync1;
            win_cnt   <= win_cnt + WIN_BITS'(1);
            hi_cnt    <= (win_cnt == '0) ? TW'(s) : hi_cnt + TW'(s);
            win_end_q <= (win_cnt == WIN_LAST);
            if (win_cnt == WIN_LAST) begin
                total_q <= hi_cnt + TW'(s);
            end
        end
    end

    // State and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= PRIME;
            match_cnt  <= '0;
            prev_total <= '0;
            duty_q     <= '0;
            dv_q       <= 1'b0;
            dead_q     <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            match_cnt  <= match_nxt;
            prev_total <= prev_nxt;
            duty_q     <= duty_nxt;
            dv_q       <= dv_nxt;
            dead_q     <= dead_nxt;
            lock_q     <= lock_nxt;
        end
    end

    // First window after reset is primed away; later windows update results.
    always_comb begin
        state_nxt = state;
        match_nxt = match_cnt;
        prev_nxt  = prev_total;
        duty_nxt  = duty_q;
        dv_nxt    = 1'b0;
        dead_nxt  = dead_q;
        lock_nxt  = lock_q;

        case (state)
            PRIME: begin
                if (win_end_q) begin
                    state_nxt = TRACK;
                end
            end
            TRACK: begin
                if (win_end_q) begin
                    dv_nxt = 1'b1;
                    if (total_q == '0) begin
                        dead_nxt = 1'b1;
                    end else begin
                        dead_nxt = 1'b0;
                        duty_nxt = WIN_BITS'(total_q - TW'(1));
                    end
                    if (total_q == prev_total) begin
                        match_nxt = (match_cnt >= LOCK_M) ? LOCK_M : match_cnt + MW'(1);
                    end else begin
                        match_nxt = '0;
                    end
                    prev_nxt = total_q;
                    lock_nxt = (match_nxt >= LOCK_M);
                end
            end
            default: begin
                state_nxt = PRIME;
            end
        endcase
    end

    assign bus.duty       = duty_q;
    assign bus.duty_valid = dv_q;
    assign bus.dead       = dead_q;
    assign bus.locked     = lock_q;

endmodule
